read_loader: RTL and testbench
==============================

# read_loader

Ingress stage for the seeding engine. It takes ASCII reads as an AXI4-Stream, converts them to 2-bit-plus-N symbols, and holds them in a ping-pong buffer. It drives the `read`, `read_id` and `start` inputs of `ReadMemReseed` and releases a bank on that block's `finish`. Double buffering lets read k+1 load while read k is being seeded.

## Interface
- READ_LEN, 76: symbols per read; must be ≥1.
- TD_BYTES, 8: tdata width in bytes; one ASCII char per byte; data beats per read NB = ceil(READ_LEN/TD_BYTES).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- s_axis_read  slave  Axi4StreamIf (tdata 8*TD_BYTES, tvalid, tready, tlast)  read input:
  - beat 0 is the header, read id in tdata[31:0];
  - beats 1..NB are characters, byte b of beat j is char (j-1)*TD_BYTES+b;
  - tlast is on beat NB.
- read  out  Symbol[READ_LEN]  symbols of the active bank.
- read_id  out  32  id of the active bank.
- start  out  1  one-cycle launch pulse to the seeder.
- finish  in  1  seeder done with current read (one-cycle pulse).
- busy  in  1  seeder busy.
- err_short  out  1  one-cycle pulse: tlast arrived before beat NB.
- err_long  out  1  one-cycle pulse: beat NB arrived without tlast.
- n_launched  out  32  count of start pulses issued; wraps at 2^32.

## Operation
- Symbol map:
  - 'A'/'a' -> sym_A, 'C'/'c' -> sym_C, 'G'/'g' -> sym_G, 'T'/'t' -> sym_T.
  - Any other byte -> sym_N.
  - Bytes past READ_LEN in the final beat are ignored.
- Two banks (0/1), each holding READ_LEN symbols, a 32-bit id and a full flag.
- Fill pointer: `wbank`. Launch pointer: `rbank`. Both reset to 0.
- Fill FSM:
  - HDR: tready = !full[wbank]; header handshake stores the id and sets beat counter = 1 -> DATA. A header beat with tlast=1 is a short read: err_short, all symbols N, bank marked full.
  - DATA: tready = 1; each handshake writes TD_BYTES symbols at offset (cnt-1)*TD_BYTES.
    - tlast with cnt<NB: err_short; remaining symbols forced to sym_N; full[wbank] set; wbank toggles -> HDR.
    - cnt==NB with tlast: full set, wbank toggles -> HDR.
    - cnt==NB without tlast: err_long, full set, wbank toggles -> DRAIN.
  - DRAIN: tready = 1; beats are discarded until a tlast handshake -> HDR.
- Launch FSM:
  - IDLE: when full[rbank] && !busy -> LAUNCH.
  - LAUNCH: start = 1 for this cycle only; n_launched += 1 -> RUN.
  - RUN: on finish, clear full[rbank], toggle rbank -> IDLE.
- `read`/`read_id` are combinational from bank rbank. They stay stable from start through finish because the fill FSM never writes a full bank.
- Simultaneous events:
  - Fill may set full[wbank] in the same cycle RUN clears full[rbank]; both take effect (different banks).
  - If both banks are full, tready stays 0 in HDR until a release.

## Timing
- Reset values:
  - start=0, err_short=0, err_long=0, n_launched=0.
  - Both full flags=0, wbank=rbank=0.
  - Fill FSM=HDR, launch FSM=IDLE.
  - Bank contents=all-zero (sym_A, id 0).
- Reset asserted mid-read:
  - Partial bank contents are discarded.
  - Any in-flight seeder run is abandoned, with no start and no release.
  - A finish arriving after reset deassertion while in IDLE is ignored.
- Latency: final data beat accepted at edge k, seeder idle:
  - full is set at edge k.
  - Launch FSM enters LAUNCH at edge k+1.
  - start is high during cycle k+1..k+2.
- Back-to-back reads: finish at edge f, next bank already full -> IDLE at f, LAUNCH at f+1. That is 2 cycles of seeder idle.
- Throughput: one beat per cycle while the fill bank is free; no bubbles between header and data or between reads.
- err pulses are registered, high the cycle after the offending handshake.
- A finish arriving outside RUN is ignored.

## Test plan
- Single read, READ_LEN=76, TD_BYTES=8:
  - Stimulus: header id 0x01234567, 10 data beats "TGTCAGGG…CCCC" with tlast on beat 10, busy=0.
  - Required: start pulses once, 2 cycles after the last beat; read[0]=sym_T, read[75]=sym_C; read_id=0x01234567; n_launched=1.
- Case and N handling: chars "acgtNx-" at positions 0..6 -> sym_A, sym_C, sym_G, sym_T, sym_N, sym_N, sym_N.
- Ping-pong:
  - Stimulus: stream three reads back-to-back; seeder finish 200 cycles after each start.
  - Required: reads 1 and 2 accepted with no stall; tready low after the third header arrives until the first finish; starts occur in order with ids preserved; read stable across each run.
- Short read: tlast on data beat 5 -> err_short one pulse; symbols 40..75 = sym_N; read still launched.
- Long read: 13 data beats, tlast on beat 13:
  - err_long pulses after beat 10.
  - Beats 11-13 are dropped.
  - The next header is parsed correctly.
- Reset mid-fill:
  - Stimulus: assert rst asynchronously after 4 data beats; release; send a full read.
  - Required: outputs return to reset values immediately; exactly one start follows the new read, with the new id.

Source files
------------

// File: rtl/read_loader.sv
// Ingress stage for the seeding engine: ASCII AXI4-Stream reads -> 3-bit symbols
// held in a two-bank ping-pong buffer, launched one at a time into the seeder.
module read_loader #(
  parameter int READ_LEN = 76,
  parameter int TD_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*TD_BYTES-1:0]   s_axis_tdata_i,
  input  logic                    s_axis_tvalid_i,
  output logic                    s_axis_tready_o,
  input  logic                    s_axis_tlast_i,
  output logic [3*READ_LEN-1:0]   read_o,
  output logic [31:0]             read_id_o,
  output logic                    start_o,
  input  logic                    finish_i,
  input  logic                    busy_i,
  output logic                    err_short_o,
  output logic                    err_long_o,
  output logic [31:0]             n_launched_o
);

  localparam int NB = (READ_LEN + TD_BYTES - 1) / TD_BYTES;
  localparam int CW = $clog2(NB + 1);

  localparam logic [2:0] SYM_A = 3'd0;
  localparam logic [2:0] SYM_C = 3'd1;
  localparam logic [2:0] SYM_G = 3'd2;
  localparam logic [2:0] SYM_T = 3'd3;
  localparam logic [2:0] SYM_N = 3'd4;

  typedef enum logic [1:0] {F_HDR, F_DATA, F_DRAIN} fill_t;
  typedef enum logic [1:0] {L_IDLE, L_LAUNCH, L_RUN} launch_t;

  fill_t         fill_q;
  launch_t       launch_q;
  logic          wbank_q, rbank_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    full_q, full_d;
  logic [2:0]    sym_q [2][READ_LEN];
  logic [31:0]   id_q [2];
  logic          err_short_q, err_long_q, start_q;
  logic [31:0]   n_launched_q;

  logic hs, last_beat, fill_done, release_bank;

  function automatic logic [2:0] char2sym(input logic [7:0] c);
    case (c)
      8'h41, 8'h61: return SYM_A;
      8'h43, 8'h63: return SYM_C;
      8'h47, 8'h67: return SYM_G;
      8'h54, 8'h74: return SYM_T;
      default:      return SYM_N;
    endcase
  endfunction

  // A full fill bank can only be seen in HDR; DATA/DRAIN always own a free bank.
  assign s_axis_tready_o = (fill_q == F_HDR) ? !full_q[wbank_q] : 1'b1;
  assign hs        = s_axis_tvalid_i && s_axis_tready_o;
  assign last_beat = (cnt_q == CW'(NB));
  assign fill_done = hs && (((fill_q == F_HDR) && s_axis_tlast_i) ||
                            ((fill_q == F_DATA) && (s_axis_tlast_i || last_beat)));
  assign release_bank = (launch_q == L_RUN) && finish_i;

  always_ff @(posedge clk or posedge rst) begin : fill_fsm
    if (rst) begin
      fill_q      <= F_HDR;
      wbank_q     <= 1'b0;
      cnt_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        id_q[b] <= '0;
        for (int p = 0; p < READ_LEN; p++) sym_q[b][p] <= SYM_A;
      end
    end else begin
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      if (hs) begin
        case (fill_q)
          F_HDR: begin
            id_q[wbank_q] <= s_axis_tdata_i[31:0];
            if (s_axis_tlast_i) begin
              err_short_q <= 1'b1;
              wbank_q     <= ~wbank_q;
              for (int p = 0; p < READ_LEN; p++) sym_q[wbank_q][p] <= SYM_N;
            end else begin
              cnt_q  <= CW'(1);
              fill_q <= F_DATA;
            end
          end
          F_DATA: begin
            // Positions of this beat take the mapped char; a short read pads the tail with N.
            for (int p = 0; p < READ_LEN; p++) begin
              if (p / TD_BYTES == int'(cnt_q) - 1)
                sym_q[wbank_q][p] <= char2sym(s_axis_tdata_i[8*(p % TD_BYTES) +: 8]);
              else if (s_axis_tlast_i && (p / TD_BYTES >= int'(cnt_q)))
                sym_q[wbank_q][p] <= SYM_N;
            end
            if (s_axis_tlast_i || last_beat) begin
              wbank_q     <= ~wbank_q;
              fill_q      <= s_axis_tlast_i ? F_HDR : F_DRAIN;
              err_short_q <= s_axis_tlast_i && !last_beat;
              err_long_q  <= !s_axis_tlast_i;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          F_DRAIN: if (s_axis_tlast_i) fill_q <= F_HDR;
          default: fill_q <= F_HDR;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : launch_fsm
    if (rst) begin
      launch_q     <= L_IDLE;
      rbank_q      <= 1'b0;
      start_q      <= 1'b0;
      n_launched_q <= '0;
    end else begin
      start_q <= 1'b0;
      case (launch_q)
        L_IDLE: if (full_q[rbank_q] && !busy_i) begin
          launch_q     <= L_LAUNCH;
          start_q      <= 1'b1;
          n_launched_q <= n_launched_q + 32'd1;
        end
        L_LAUNCH: launch_q <= L_RUN;
        L_RUN: if (finish_i) begin
          rbank_q  <= ~rbank_q;
          launch_q <= L_IDLE;
        end
        default: launch_q <= L_IDLE;
      endcase
    end
  end

  // Set and release never target the same bank: fill never owns a full bank.
  always_comb begin
    full_d = full_q;
    if (release_bank) full_d[rbank_q] = 1'b0;
    if (fill_done)    full_d[wbank_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= '0;
    else     full_q <= full_d;
  end

  for (genvar p = 0; p < READ_LEN; p++) begin : g_read
    assign read_o[3*p +: 3] = sym_q[rbank_q][p];
  end

  assign read_id_o    = id_q[rbank_q];
  assign start_o      = start_q;
  assign err_short_o  = err_short_q;
  assign err_long_o   = err_long_q;
  assign n_launched_o = n_launched_q;

endmodule

// File: tb/tb_read_loader.sv
// Directed bench for read_loader: launch timing, symbol map, ping-pong, short/long reads, reset.
module tb_read_loader;
  localparam int RL = 76;
  localparam int TB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [8*TB-1:0] tdata = '0;
  logic tvalid = 1'b0, tlast = 1'b0, tready;
  logic [3*RL-1:0] read_o;
  logic [31:0] read_id, n_launched;
  logic start, finish = 1'b0, busy = 1'b0, err_short, err_long;

  read_loader #(.READ_LEN(RL), .TD_BYTES(TB)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata_i(tdata), .s_axis_tvalid_i(tvalid), .s_axis_tready_o(tready),
    .s_axis_tlast_i(tlast),
    .read_o(read_o), .read_id_o(read_id), .start_o(start),
    .finish_i(finish), .busy_i(busy),
    .err_short_o(err_short), .err_long_o(err_long), .n_launched_o(n_launched)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int start_cnt = 0, errs_cnt = 0, errl_cnt = 0, last_start_cyc = 0, last_fin_cyc = 0;
  logic [7:0] rd [0:127];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start)     begin start_cnt <= start_cnt + 1; last_start_cyc <= cyc; end
    if (finish)    last_fin_cyc <= cyc;
    if (err_short) errs_cnt <= errs_cnt + 1;
    if (err_long)  errl_cnt <= errl_cnt + 1;
  end

  function automatic logic [2:0] sym_at(input int p);
    return read_o[3*p +: 3];
  endfunction

  function automatic logic [8*TB-1:0] beat(input int j);
    logic [8*TB-1:0] w;
    for (int b = 0; b < TB; b++) w[8*b +: 8] = rd[(j-1)*TB + b];
    return w;
  endfunction

  task automatic fill_acgt();
    for (int i = 0; i < 128; i++)
      case (i % 4)
        0: rd[i] = 8'h41;
        1: rd[i] = 8'h43;
        2: rd[i] = 8'h47;
        default: rd[i] = 8'h54;
      endcase
  endtask

  // Drives one beat from a posedge+1 alignment; returns at posedge+1 after the handshake.
  task automatic send_beat(input logic [8*TB-1:0] d, input logic last, output int stall);
    bit done;
    done = 0; stall = 0;
    tdata = d; tvalid = 1'b1; tlast = last;
    while (!done) begin
      @(negedge clk);
      done = tready;
      @(posedge clk); #1;
      if (!done) begin
        stall++;
        if (stall > 3000) begin
          checks++; failures++;
          $display("FAIL handshake_timeout: beat not accepted after %0d cycles, required acceptance", stall);
          done = 1;
        end
      end
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_read(input logic [31:0] id, input int nbeats, input int last_at,
                           output int hstall, output int dstall);
    int s;
    @(posedge clk); #1;
    send_beat({32'h0, id}, last_at == 0, hstall);
    dstall = 0;
    for (int j = 1; j <= nbeats; j++) begin
      send_beat(beat(j), j == last_at, s);
      dstall += s;
    end
  endtask

  task automatic wait_start(input int n, output bit ok);
    int t;
    t = 0; ok = 1;
    while (start_cnt < n) begin
      @(negedge clk); #1;
      t++;
      if (t > 3000) begin ok = 0; break; end
    end
  endtask

  task automatic pulse_finish();
    @(posedge clk); #1 finish = 1'b1;
    @(posedge clk); #1 finish = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b want 0", start); end
    checks++; if (n_launched !== 32'd0) begin failures++; $display("FAIL reset_nlaunch: got %0d want 0", n_launched); end
    checks++; if ({err_short, err_long} !== 2'b00) begin failures++; $display("FAIL reset_err: got %b want 00", {err_short, err_long}); end
    checks++; if (tready !== 1'b1) begin failures++; $display("FAIL reset_tready: got %b want 1", tready); end
    checks++; if (read_id !== 32'd0) begin failures++; $display("FAIL reset_id: got %h want 0", read_id); end
    checks++; if (read_o !== '0) begin failures++; $display("FAIL reset_syms: got nonzero want all sym_A"); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single();
    int h, d, s0; bit ok;
    s0 = start_cnt;
    for (int i = 0; i < 8; i++) rd[i] = (i == 0 || i == 2) ? 8'h54 : (i == 1 || i >= 5) ? 8'h47 : (i == 3) ? 8'h43 : 8'h41;
    for (int i = 8; i < 72; i++) rd[i] = ((i - 8) % 4 == 0) ? 8'h41 : ((i - 8) % 4 == 1) ? 8'h43 : ((i - 8) % 4 == 2) ? 8'h47 : 8'h54;
    for (int i = 72; i < 76; i++) rd[i] = 8'h43;
    for (int i = 76; i < 80; i++) rd[i] = 8'h47;
    send_read(32'h01234567, 10, 10, h, d);
    @(negedge clk);
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL single_start_k: got %b want 0", start); end
    @(negedge clk);
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL single_start_k1: got %b want 1", start); end
    @(negedge clk);
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL single_start_k2: got %b want 0", start); end
    wait_start(s0 + 1, ok);
    checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL single_nstart: got %0d want 1", start_cnt - s0); end
    checks++; if (read_id !== 32'h01234567) begin failures++; $display("FAIL single_id: got %h want 01234567", read_id); end
    checks++; if (sym_at(0) !== 3'd3) begin failures++; $display("FAIL single_sym0: got %0d want 3", sym_at(0)); end
    checks++; if (sym_at(3) !== 3'd1) begin failures++; $display("FAIL single_sym3: got %0d want 1", sym_at(3)); end
    checks++; if (sym_at(9) !== 3'd1) begin failures++; $display("FAIL single_sym9: got %0d want 1", sym_at(9)); end
    checks++; if (sym_at(75) !== 3'd1) begin failures++; $display("FAIL single_sym75: got %0d want 1", sym_at(75)); end
    checks++; if (n_launched !== 32'd1) begin failures++; $display("FAIL single_nlaunch: got %0d want 1", n_launched); end
    checks++; if (h + d !== 0) begin failures++; $display("FAIL single_stall: got %0d want 0", h + d); end
    pulse_finish();
    repeat (10) @(posedge clk);
    #1;
    checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL single_nostray: got %0d starts want 1", start_cnt - s0); end
  endtask

  task automatic test_case_n();
    int h, d, s0; bit ok;
    logic [2:0] exp [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    logic [7:0] ch [7] = '{8'h61, 8'h63, 8'h67, 8'h74, 8'h4E, 8'h78, 8'h2D};
    s0 = start_cnt;
    for (int i = 0; i < 128; i++) rd[i] = 8'h41;
    for (int i = 0; i < 7; i++) rd[i] = ch[i];
    send_read(32'h0000CA5E, 10, 10, h, d);
    wait_start(s0 + 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL case_start: got no start want 1"); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (sym_at(i) !== exp[i]) begin failures++; $display("FAIL case_sym%0d: got %0d want %0d", i, sym_at(i), exp[i]); end
    end
    pulse_finish();
  endtask

  task automatic test_short();
    int h, d, s0, e0, l0, badn; bit ok;
    s0 = start_cnt; e0 = errs_cnt; l0 = errl_cnt;
    for (int i = 0; i < 128; i++) rd[i] = 8'h54;
    send_read(32'h000005A0, 5, 5, h, d);
    wait_start(s0 + 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL short_start: got no start want 1"); end
    checks++; if (errs_cnt - e0 !== 1) begin failures++; $display("FAIL short_err: got %0d pulses want 1", errs_cnt - e0); end
    checks++; if (errl_cnt - l0 !== 0) begin failures++; $display("FAIL short_errlong: got %0d pulses want 0", errl_cnt - l0); end
    checks++; if (sym_at(39) !== 3'd3) begin failures++; $display("FAIL short_sym39: got %0d want 3", sym_at(39)); end
    badn = 0;
    for (int p = 40; p < RL; p++) if (sym_at(p) !== 3'd4) badn++;
    checks++; if (badn !== 0) begin failures++; $display("FAIL short_tailN: got %0d non-N symbols want 0", badn); end
    checks++; if (read_id !== 32'h000005A0) begin failures++; $display("FAIL short_id: got %h want 000005a0", read_id); end
    pulse_finish();
  endtask

  task automatic test_long();
    int h, d, s0, e0, l0; bit ok;
    s0 = start_cnt; e0 = errs_cnt; l0 = errl_cnt;
    for (int i = 0; i < 80; i++) rd[i] = 8'h47;
    for (int i = 80; i < 128; i++) rd[i] = 8'h54;
    send_read(32'h0000010C, 13, 13, h, d);
    wait_start(s0 + 1, ok);
    checks++; if (errl_cnt - l0 !== 1) begin failures++; $display("FAIL long_err: got %0d pulses want 1", errl_cnt - l0); end
    checks++; if (errs_cnt - e0 !== 0) begin failures++; $display("FAIL long_errshort: got %0d pulses want 0", errs_cnt - e0); end
    checks++; if (d !== 0) begin failures++; $display("FAIL long_drain_stall: got %0d want 0", d); end
    checks++; if (read_id !== 32'h0000010C) begin failures++; $display("FAIL long_id: got %h want 0000010c", read_id); end
    checks++; if (sym_at(75) !== 3'd2) begin failures++; $display("FAIL long_sym75: got %0d want 2", sym_at(75)); end
    pulse_finish();
    fill_acgt();
    send_read(32'h0000BEEF, 10, 10, h, d);
    wait_start(s0 + 2, ok);
    checks++; if (!ok || read_id !== 32'h0000BEEF) begin failures++; $display("FAIL long_next_id: got %h want 0000beef", read_id); end
    checks++; if (sym_at(1) !== 3'd1) begin failures++; $display("FAIL long_next_sym1: got %0d want 1", sym_at(1)); end
    pulse_finish();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ids [3] = '{32'hA0000001, 32'hA0000002, 32'hA0000003};
    int h0, d0, h1, d1, h2, d2, s, hdr3_cyc, fin0_cyc, s0;
    s0 = start_cnt;
    fill_acgt();
    fork
      begin
        send_read(ids[0], 10, 10, h0, d0);
        send_read(ids[1], 10, 10, h1, d1);
        @(posedge clk); #1;
        send_beat({32'h0, ids[2]}, 1'b0, h2);
        hdr3_cyc = cyc;
        d2 = 0;
        for (int j = 1; j <= 10; j++) begin send_beat(beat(j), j == 10, s); d2 += s; end
      end
      begin
        for (int r = 0; r < 3; r++) begin
          logic [3*RL-1:0] snap; logic [31:0] idsnap; bit ok;
          wait_start(s0 + r + 1, ok);
          snap = read_o; idsnap = read_id;
          checks++; if (!ok || idsnap !== ids[r]) begin failures++; $display("FAIL pp_id%0d: got %h want %h", r, idsnap, ids[r]); end
          if (r > 0) begin
            checks++; if (last_start_cyc - last_fin_cyc !== 2) begin failures++; $display("FAIL pp_gap%0d: got %0d want 2", r, last_start_cyc - last_fin_cyc); end
          end
          repeat (199) @(posedge clk);
          #1;
          checks++; if (read_o !== snap || read_id !== idsnap) begin failures++; $display("FAIL pp_stable%0d: got id %h want %h", r, read_id, idsnap); end
          pulse_finish();
          if (r == 0) begin @(negedge clk); #1 fin0_cyc = last_fin_cyc; end
        end
      end
    join
    checks++; if (h0 + d0 + h1 + d1 !== 0) begin failures++; $display("FAIL pp_nostall: got %0d stall cycles want 0", h0 + d0 + h1 + d1); end
    checks++; if (h2 < 150) begin failures++; $display("FAIL pp_hdr3_stall: got %0d want >=150", h2); end
    checks++; if (hdr3_cyc !== fin0_cyc + 2) begin failures++; $display("FAIL pp_hdr3_release: got cycle %0d want %0d", hdr3_cyc, fin0_cyc + 2); end
    checks++; if (d2 !== 0) begin failures++; $display("FAIL pp_read3_data_stall: got %0d want 0", d2); end
  endtask

  task automatic test_reset_mid();
    int h, d, s, s0; bit ok;
    s0 = start_cnt;
    fill_acgt();
    send_read(32'h00000011, 10, 10, h, d);
    wait_start(s0 + 1, ok);
    @(posedge clk); #1;
    send_beat({32'h0, 32'h00000022}, 1'b0, s);
    for (int j = 1; j <= 4; j++) send_beat(beat(j), 1'b0, s);
    #2 rst = 1'b1;
    #1;
    checks++; if (start !== 1'b0 || n_launched !== 32'd0) begin failures++; $display("FAIL rstmid_launch: got start=%b n=%0d want 0/0", start, n_launched); end
    checks++; if (tready !== 1'b1 || read_id !== 32'd0) begin failures++; $display("FAIL rstmid_state: got tready=%b id=%h want 1/0", tready, read_id); end
    checks++; if (read_o !== '0) begin failures++; $display("FAIL rstmid_syms: got nonzero want all sym_A"); end
    @(negedge clk); rst = 1'b0;
    s0 = start_cnt;
    pulse_finish();
    repeat (5) @(posedge clk);
    #1;
    checks++; if (start_cnt !== s0) begin failures++; $display("FAIL rstmid_nostart: got %0d starts want 0", start_cnt - s0); end
    send_read(32'h00000033, 10, 10, h, d);
    wait_start(s0 + 1, ok);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL rstmid_onestart: got %0d want 1", start_cnt - s0); end
    checks++; if (read_id !== 32'h00000033) begin failures++; $display("FAIL rstmid_id: got %h want 00000033", read_id); end
    checks++; if (n_launched !== 32'd1) begin failures++; $display("FAIL rstmid_nlaunch: got %0d want 1", n_launched); end
    pulse_finish();
  endtask

  initial begin
    test_reset();
    test_single();
    test_case_n();
    test_short();
    test_long();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
